// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and cell-grid geometry.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int CELLS_X = 32;
    localparam int CELLS_Y = 32;

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, 800x525 h/v counters, raw (undelayed) sync and visible flags, frame_start.
module vga_timing import vga_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_pix_tick,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_visible,
    output logic       o_frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_run;
    logic [9:0]       r_h;
    logic [9:0]       r_v;

    // r_run keeps the divider at 0 on the first clock after reset so pixel (0,0) gets a full CLK_DIV clocks
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run <= 1'b0;
            r_div <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run)
                r_div <= o_pix_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (o_pix_tick) begin
            if (r_h == 10'(H_TOTAL - 1)) begin
                r_h <= '0;
                r_v <= (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    assign o_pix_tick    = r_run && (r_div == DIV_W'(CLK_DIV - 1));
    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_hsync_n     = !((r_h >= 10'(H_SYNC_START)) && (r_h < 10'(H_SYNC_END)));
    assign o_vsync_n     = !((r_v >= 10'(V_SYNC_START)) && (r_v < 10'(V_SYNC_END)));
    assign o_visible     = r_run && (r_h < 10'(H_VISIBLE)) && (r_v < 10'(V_VISIBLE));
    assign o_frame_start = o_pix_tick && (r_h == 10'd0) && (r_v == 10'd0);

endmodule

// File: rtl/vga_cell_scan.sv
// Cell-grid VGA scanner: one RGB565 word per 20x15 cell, RGB444 out with 1-pixel latency.
// Build macro VGA_BORDER_EN forces a white one-pixel border around the visible area.
module vga_cell_scan import vga_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter int CELL_W  = 20,
    parameter int CELL_H  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_en,
    output logic [9:0]  mem_addr,
    input  logic [15:0] mem_dout,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int SX_W = $clog2(CELL_W);
    localparam int SY_W = $clog2(CELL_H);

    logic            w_tick;
    logic [9:0]      w_h;
    logic [9:0]      w_v;
    logic            w_hsync_n;
    logic            w_vsync_n;
    logic            w_visible;
    logic [SX_W-1:0] r_sub_x;
    logic [SY_W-1:0] r_sub_y;
    logic [4:0]      r_col;
    logic [4:0]      r_row;
    logic [11:0]     w_rgb_p0;
    logic            r_hsync_p1;
    logic            r_vsync_p1;
    logic [11:0]     r_rgb_p1;
`ifdef VGA_BORDER_EN
    logic            w_border;
`endif

    vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_pix_tick   (w_tick),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_hsync_n    (w_hsync_n),
        .o_vsync_n    (w_vsync_n),
        .o_visible    (w_visible),
        .o_frame_start(frame_start)
    );

    function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
        return {4'(px >> 12), 4'(px >> 7), 4'(px >> 1)};
    endfunction

    // Cell counters track (h, v) incrementally and saturate at the last cell through blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub_x <= '0;
            r_col   <= '0;
            r_sub_y <= '0;
            r_row   <= '0;
        end else if (w_tick) begin
            if (w_h == 10'(H_TOTAL - 1)) begin
                r_sub_x <= '0;
                r_col   <= '0;
                if (w_v == 10'(V_TOTAL - 1)) begin
                    r_sub_y <= '0;
                    r_row   <= '0;
                end else if (w_v < 10'(V_VISIBLE)) begin
                    if (r_sub_y == SY_W'(CELL_H - 1)) begin
                        r_sub_y <= '0;
                        if (r_row != 5'(CELLS_Y - 1))
                            r_row <= r_row + 5'd1;
                    end else begin
                        r_sub_y <= r_sub_y + SY_W'(1);
                    end
                end
            end else if (w_h < 10'(H_VISIBLE)) begin
                if (r_sub_x == SX_W'(CELL_W - 1)) begin
                    r_sub_x <= '0;
                    if (r_col != 5'(CELLS_X - 1))
                        r_col <= r_col + 5'd1;
                end else begin
                    r_sub_x <= r_sub_x + SX_W'(1);
                end
            end
        end
    end

    assign mem_en   = w_visible;
    assign mem_addr = {r_row, r_col};

`ifdef VGA_BORDER_EN
    assign w_border = (w_h == 10'd0) || (w_h == 10'(H_VISIBLE - 1)) ||
                      (w_v == 10'd0) || (w_v == 10'(V_VISIBLE - 1));
`endif

    // p0: colour for the current (h, v); memory data has settled by the tick since CLK_DIV >= 2
    always_comb begin
        w_rgb_p0 = rgb565_to_444(mem_dout);
`ifdef VGA_BORDER_EN
        if (w_border)
            w_rgb_p0 = 12'hFFF;
`endif
        if (!w_visible)
            w_rgb_p0 = '0;
    end

    // p1: syncs and colour registered together on the pixel tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync_p1 <= 1'b1;
            r_vsync_p1 <= 1'b1;
            r_rgb_p1   <= '0;
        end else if (w_tick) begin
            r_hsync_p1 <= w_hsync_n;
            r_vsync_p1 <= w_vsync_n;
            r_rgb_p1   <= w_rgb_p0;
        end
    end

    assign hsync = r_hsync_p1;
    assign vsync = r_vsync_p1;
    assign rgb   = r_rgb_p1;

endmodule
